jtpang_eeprom: RTL
==================

# jtpang_eeprom

Serial EEPROM responder for the Pang/Mitchell main board: a 93C46-compatible, 64×16-bit Microwire device driven by the main CPU's bit-banged `eeprom_cs`/`eeprom_clk`/`eeprom_din` latches, returning `eeprom_dout` to the system status byte. It decodes READ/WRITE/ERASE/EWEN/EWDS/ERAL/WRAL, stores data in on-chip RAM, and exposes a byte-wide port so the framework can dump and restore the NVRAM contents.

## Interface
Parameters:
- `BUSY_CYC`, 16'd2000: `clk` cycles a program/erase operation reports busy. Used only with `JTPANG_EEPROM_BUSY_EN`.

Ports:
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst_n` in 1: reset. Synchronous, active-low.
- `scs` in 1: chip select. Active high.
- `sclk` in 1: serial clock. A level register that is synchronous to `clk`.
- `sdi` in 1: serial data in.
- `sdo` out 1: serial data out. Idle value is 1.
- `prog_addr` in 7: dump-port byte address. Bits [6:1] select the word; bit [0]=0 selects the low byte, 1 the high byte.
- `prog_data` in 8: dump-port write data.
- `prog_we` in 1: dump-port write strobe.
- `prog_din` out 8: dump-port read data. Registered, 1-cycle latency.

## Operation
- Edge detection:
  - `sclk_l` registers `sclk`.
  - A rising edge is `sclk & ~sclk_l`. All serial actions occur only in a `clk` cycle where this edge is detected and `scs`=1.
- `scs`=0 forces state IDLE. The shift counters clear.
- State flow:
  - IDLE→START when `scs`=1.
  - START: `sdi`=0 edges are ignored. On an `sdi`=1 edge → OP.
  - OP: shift in 2 bits → ADDR.
  - ADDR: shift in 6 bits, MSB first, into `addr`. On the 6th edge, decode.
- Decode:
  - 10 READ → RD. The output register is loaded with `mem[addr]`.
  - 01 WRITE → DIN.
  - 11 ERASE → DONE, with the erase pending.
  - 00 with `addr[5:4]`:
    - 11 EWEN: `wen`←1, → DONE.
    - 00 EWDS: `wen`←0, → DONE.
    - 10 ERAL: → DONE, with erase-all pending.
    - 01 WRAL: → DIN.
- RD state:
  - `sdo`=0 (dummy bit) from the decode edge.
  - Each following edge drives the next data bit, MSB first.
  - After bit 0, the next edge loads `mem[addr+1]` (6-bit wrap, 63→0) and drives its MSB. This gives a continuous sequential read.
- DIN state: shift 16 bits, MSB first. Edges after the 16th are ignored.
- Commit happens on `scs` 1→0, only if `wen`=1 and the command completed (16 data bits, or an ERASE/ERAL decode). Otherwise the command is discarded.
  - WRITE: `mem[addr]`←data.
  - ERASE: `mem[addr]`←16'hFFFF.
  - ERAL / WRAL: a sweep engine writes FFFF or data to words 0..63, one word per `clk`, over 64 cycles. A new command may be shifted in during the sweep. Commit of that new command waits until the sweep ends.
- Status output:
  - `sdo`=1 whenever not in RD, except for the busy indication.
  - With `scs`=1 in START while busy, `sdo`=0.
- Dump port:
  - Read: `prog_din` ← the selected byte of `mem[prog_addr[6:1]]`.
  - Write: `prog_we` writes the selected byte.
  - When `prog_we` and an internal write fall in the same cycle, `prog_we` wins and the internal write of that word is lost. The sweep still advances.
- Reset:
  - Forces IDLE and `wen`=0.
  - Aborts any sweep and clears busy.
  - Sets `sdo`=1 and `prog_din`=0.
  - Memory contents are preserved.

## Timing
- `sdo` updates in the `clk` cycle after the detected `sclk` edge (registered output).
- An `scs` falling edge is detected 1 cycle after the fall. A single write commits on that cycle. A sweep starts on that cycle and ends 64 cycles later.
- `scs` dropping mid-command (any state) aborts the command with no memory change.
- An `sclk` edge coincident with `scs` going 0 is ignored.
- Simultaneous `scs` rise and `sclk` rise: the edge counts as the first START bit.

## Configuration
- `JTPANG_EEPROM_BUSY_EN` defined:
  - Each commit loads a busy counter with `BUSY_CYC`. A sweep loads it when the sweep ends.
  - The counter decrements every cycle. Busy = counter≠0.
  - Commands that complete decode while busy are discarded.
- Undefined:
  - The busy counter is not built. Busy is asserted only during a sweep.
  - `sdo` returns 1 immediately after a single-word commit.

## Test plan
- Write then read: EWEN; WRITE addr 5 data 16'hA55A; drop `scs`; READ addr 5 → `sdo` shows 0 then 1010010101011010.
- Write protection: after reset (`wen`=0), WRITE addr 3 = 16'h1234 → read gives the prior value; dump port byte 6 unchanged.
- Sequential read across wrap: preload via dump port word 63 = 16'h00FF and word 0 = 16'hFF00; READ addr 63 for 33 edges → dummy 0, 00FF, FF00.
- WRAL/ERAL: EWEN; WRAL 16'hBEEF → after 64 cycles all 128 dump bytes read EF/BE alternately; ERAL → all bytes FF.
- Busy (`JTPANG_EEPROM_BUSY_EN`, `BUSY_CYC`=10): WRITE commit, raise `scs` → `sdo`=0 for the remaining count, then 1. A READ issued while busy has no effect.
- Abort/reset: drop `scs` after 8 of 16 data bits → memory unchanged. Assert `rst_n`=0 mid-sweep → sweep stops, `wen`=0, `sdo`=1, already-written words keep their new values.

Source files
------------

// File: rtl/jtpang_eeprom.sv
// 93C46-style 64x16 Microwire EEPROM responder with byte-wide dump port; sdo and prog_din are registered (1 clk).
// No backpressure: serial side is host-paced, dump port always accepts; JTPANG_EEPROM_BUSY_EN adds a post-program busy timer.
module jtpang_eeprom #(
    parameter logic [15:0] BUSY_CYC = 16'd2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scs,
    input  logic       sclk,
    input  logic       sdi,
    output logic       sdo,
    input  logic [6:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       prog_we,
    output logic [7:0] prog_din
);
    typedef enum logic [2:0] {IDLE, START, OP, ADDR, RD, DIN, DONE} state_t;
    typedef enum logic [2:0] {K_NONE, K_WRITE, K_ERASE, K_ERAL, K_WRAL} kind_t;

    logic [15:0] mem [0:63];

    state_t      state, state_nxt;
    kind_t       kind, kind_nxt, p_kind, go_kind;
    logic        sclk_l, scs_l, sedge, fall;
    logic [1:0]  op, op_nxt;
    logic [5:0]  addr, addr_nxt, p_addr, go_addr;
    logic [4:0]  cnt, cnt_nxt;
    logic [15:0] shreg, shreg_nxt, p_data, go_data, rd_word;
    logic        done, done_nxt, wen, wen_nxt, rd_bit, sdo_nxt;
    logic        sweep, pend, go, commit_ok, busy, busy_ind;
    logic [5:0]  sw_idx;
    logic [15:0] sw_data;
    logic        iwe;
    logic [5:0]  iaddr;
    logic [15:0] idata;

    assign sedge     = sclk & ~sclk_l & scs;
    assign fall      = scs_l & ~scs;
    assign commit_ok = fall & done & wen & (kind != K_NONE);

`ifdef JTPANG_EEPROM_BUSY_EN
    logic [15:0] busy_cnt;
    assign busy = busy_cnt != 16'd0;
    always_ff @(posedge clk) begin
        if (!rst_n)
            busy_cnt <= '0;
        else if (go && (go_kind == K_WRITE || go_kind == K_ERASE))
            busy_cnt <= BUSY_CYC;
        else if (sweep && sw_idx == 6'd63)
            busy_cnt <= BUSY_CYC;
        else if (busy)
            busy_cnt <= busy_cnt - 16'd1;
    end
`else
    logic unused_busy_cyc;
    assign unused_busy_cyc = ^BUSY_CYC;
    assign busy = 1'b0;
`endif
    assign busy_ind = busy | sweep;

    always_comb begin
        state_nxt = state;
        kind_nxt  = kind;
        op_nxt    = op;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        done_nxt  = done;
        wen_nxt   = wen;
        rd_bit    = sdo;
        rd_word   = '0;
        if (!scs) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
            kind_nxt  = K_NONE;
        end else if (sedge) begin
            case (state)
                IDLE, START: begin
                    if (sdi) begin
                        state_nxt = OP;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b0;
                        kind_nxt  = K_NONE;
                    end else begin
                        state_nxt = START;
                    end
                end
                OP: begin
                    op_nxt  = {op[0], sdi};
                    cnt_nxt = cnt + 5'd1;
                    if (cnt == 5'd1) begin
                        state_nxt = ADDR;
                        cnt_nxt   = '0;
                    end
                end
                ADDR: begin
                    addr_nxt = {addr[4:0], sdi};
                    cnt_nxt  = cnt + 5'd1;
                    if (cnt == 5'd5) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                        // While the busy timer runs every decoded command is dropped.
                        if (!busy) begin
                            case (op)
                                2'b10: begin
                                    state_nxt = RD;
                                    rd_bit    = 1'b0;
                                    shreg_nxt = mem[addr_nxt];
                                end
                                2'b01: begin
                                    state_nxt = DIN;
                                    kind_nxt  = K_WRITE;
                                end
                                2'b11: begin
                                    kind_nxt = K_ERASE;
                                    done_nxt = 1'b1;
                                end
                                default: begin
                                    case (addr_nxt[5:4])
                                        2'b11: wen_nxt = 1'b1;
                                        2'b00: wen_nxt = 1'b0;
                                        2'b10: begin
                                            kind_nxt = K_ERAL;
                                            done_nxt = 1'b1;
                                        end
                                        default: begin
                                            state_nxt = DIN;
                                            kind_nxt  = K_WRAL;
                                        end
                                    endcase
                                end
                            endcase
                        end
                    end
                end
                RD: begin
                    // After the LSB, roll over to the next word for sequential reads.
                    if (cnt == 5'd16) begin
                        addr_nxt  = addr + 6'd1;
                        rd_word   = mem[addr_nxt];
                        rd_bit    = rd_word[15];
                        shreg_nxt = {rd_word[14:0], 1'b0};
                        cnt_nxt   = 5'd1;
                    end else begin
                        rd_bit    = shreg[15];
                        shreg_nxt = {shreg[14:0], 1'b0};
                        cnt_nxt   = cnt + 5'd1;
                    end
                end
                DIN: begin
                    if (cnt != 5'd16) begin
                        shreg_nxt = {shreg[14:0], sdi};
                        cnt_nxt   = cnt + 5'd1;
                        if (cnt == 5'd15)
                            done_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (state == IDLE) begin
            state_nxt = START;
        end

        if (state_nxt == RD)
            sdo_nxt = rd_bit;
        else if (state_nxt == START && busy_ind)
            sdo_nxt = 1'b0;
        else
            sdo_nxt = 1'b1;
    end

    // A commit that lands during a sweep is parked until the sweep finishes.
    always_comb begin
        go      = 1'b0;
        go_kind = kind;
        go_addr = addr;
        go_data = shreg;
        if (pend && !sweep) begin
            go      = 1'b1;
            go_kind = p_kind;
            go_addr = p_addr;
            go_data = p_data;
        end else if (commit_ok && !sweep) begin
            go = 1'b1;
        end
        iwe   = 1'b0;
        iaddr = sw_idx;
        idata = sw_data;
        if (sweep) begin
            iwe = 1'b1;
        end else if (go && (go_kind == K_WRITE || go_kind == K_ERASE)) begin
            iwe   = 1'b1;
            iaddr = go_addr;
            idata = (go_kind == K_ERASE) ? 16'hFFFF : go_data;
        end
        if (!rst_n || (prog_we && prog_addr[6:1] == iaddr))
            iwe = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            kind     <= K_NONE;
            op       <= '0;
            addr     <= '0;
            cnt      <= '0;
            shreg    <= '0;
            done     <= 1'b0;
            wen      <= 1'b0;
            sdo      <= 1'b1;
            sclk_l   <= 1'b0;
            scs_l    <= 1'b0;
            sweep    <= 1'b0;
            pend     <= 1'b0;
            sw_idx   <= '0;
            sw_data  <= '0;
            p_kind   <= K_NONE;
            p_addr   <= '0;
            p_data   <= '0;
            prog_din <= '0;
        end else begin
            state  <= state_nxt;
            kind   <= kind_nxt;
            op     <= op_nxt;
            addr   <= addr_nxt;
            cnt    <= cnt_nxt;
            shreg  <= shreg_nxt;
            done   <= done_nxt;
            wen    <= wen_nxt;
            sdo    <= sdo_nxt;
            sclk_l <= sclk;
            scs_l  <= scs;
            if (commit_ok && (sweep || pend)) begin
                pend   <= 1'b1;
                p_kind <= kind;
                p_addr <= addr;
                p_data <= shreg;
            end else if (go && pend) begin
                pend <= 1'b0;
            end
            if (sweep) begin
                sw_idx <= sw_idx + 6'd1;
                if (sw_idx == 6'd63)
                    sweep <= 1'b0;
            end else if (go && (go_kind == K_ERAL || go_kind == K_WRAL)) begin
                sweep   <= 1'b1;
                sw_idx  <= '0;
                sw_data <= (go_kind == K_ERAL) ? 16'hFFFF : go_data;
            end
            prog_din <= prog_addr[0] ? mem[prog_addr[6:1]][15:8] : mem[prog_addr[6:1]][7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (iwe)
            mem[iaddr] <= idata;
        if (prog_we) begin
            if (prog_addr[0])
                mem[prog_addr[6:1]][15:8] <= prog_data;
            else
                mem[prog_addr[6:1]][7:0] <= prog_data;
        end
    end
endmodule
